// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the two-requester divider arbiter: FSM encoding,
// default timeout and the fixed divide-by-zero result.
package div_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int          TIMEOUT_DEF = 64;
  localparam logic [31:0] DZ_RES      = 32'hFFFF_FFFF;

  // Counter must be able to hold the value max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Request, divider-FU and result handshake bundle for div_arbiter.
interface div_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [TAG_W-1:0] req1_tag;

  logic             fu_en;
  logic [31:0]      fu_a;
  logic [31:0]      fu_b;
  logic [31:0]      fu_res;
  logic             fu_finish;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_res;
  logic [TAG_W-1:0] out_tag;
  logic             out_src;
  logic             out_dz;
  logic             out_to;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_tag,
    input  fu_res, fu_finish, out_ready,
    output req0_ready, req1_ready,
    output fu_en, fu_a, fu_b,
    output out_valid, out_res, out_tag, out_src, out_dz, out_to
  );

  // Requesters, divider FU and result consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_tag,
    output req1_valid, req1_a, req1_b, req1_tag,
    output fu_res, fu_finish, out_ready,
    input  req0_ready, req1_ready,
    input  fu_en, fu_a, fu_b,
    input  out_valid, out_res, out_tag, out_src, out_dz, out_to
  );

endinterface

// File: rtl/div_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module rr_arb2
  import div_arbiter_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_src
);

  always_comb begin
    gnt_valid = valid0 | valid1;
    gnt_src   = valid1;
    if (valid0 && valid1) gnt_src = ~last_grant;
  end

endmodule

// File: rtl/div_arbiter.sv
// Arbitrates two requesters onto one external divider FU, one operation in
// flight, with divide-by-zero bypass and a bounded wait for the FU result.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | grant one requester; latch its operands on valid&ready
// ST_ISSUE | single-cycle fu_en pulse, timeout counter at 0
// ST_WAIT  | wait for fu_finish or counter reaching TIMEOUT
// ST_HOLD  | result presented on out_*, leave when out_ready
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  div_arbiter_if.slave bus
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  state_e             state_q, state_d;
  logic               last_q;
  logic               src_q;
  logic [31:0]        a_q, b_q, res_q;
  logic [TAG_W-1:0]   tag_q;
  logic               dz_q, to_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               gnt_valid, gnt_src;
  logic [31:0]        sel_a, sel_b;
  logic [TAG_W-1:0]   sel_tag;
  logic               ready0, ready1, fu_en, out_valid;
  logic               xfer, take_fin, take_to;

  rr_arb2 u_rr_arb2 (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_q),
    .gnt_valid  (gnt_valid),
    .gnt_src    (gnt_src)
  );

  assign sel_a   = gnt_src ? bus.req1_a   : bus.req0_a;
  assign sel_b   = gnt_src ? bus.req1_b   : bus.req0_b;
  assign sel_tag = gnt_src ? bus.req1_tag : bus.req0_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready0    = 1'b0;
    ready1    = 1'b0;
    fu_en     = 1'b0;
    out_valid = 1'b0;
    xfer      = 1'b0;
    take_fin  = 1'b0;
    take_to   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Ready is gated by rst_n so it drops the moment reset asserts.
        ready0 = rst_n & gnt_valid & ~gnt_src;
        ready1 = rst_n & gnt_valid & gnt_src;
        xfer   = rst_n & gnt_valid;
        if (xfer) state_d = (sel_b == '0) ? ST_HOLD : ST_ISSUE;
      end
      ST_ISSUE: begin
        fu_en   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.fu_finish) begin
          take_fin = 1'b1;
          state_d  = ST_HOLD;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          take_to = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      src_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      res_q  <= '0;
      dz_q   <= 1'b0;
      to_q   <= 1'b0;
    end else if (xfer) begin
      last_q <= gnt_src;
      src_q  <= gnt_src;
      a_q    <= sel_a;
      b_q    <= sel_b;
      tag_q  <= sel_tag;
      res_q  <= (sel_b == '0) ? DZ_RES : '0;
      dz_q   <= (sel_b == '0);
      to_q   <= 1'b0;
    end else if (take_fin) begin
      res_q <= bus.fu_res;
    end else if (take_to) begin
      res_q <= '0;
      to_q  <= 1'b1;
    end
  end

  // Counts cycles since issue; saturates at TIMEOUT so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q <= '0;
    end else if ((state_q == ST_ISSUE || state_q == ST_WAIT) &&
                 cnt_q != CNT_W'(TIMEOUT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.fu_en      = fu_en;
  assign bus.fu_a       = a_q;
  assign bus.fu_b       = b_q;
  assign bus.out_valid  = out_valid;
  assign bus.out_res    = res_q;
  assign bus.out_tag    = tag_q;
  assign bus.out_src    = src_q;
  assign bus.out_dz     = dz_q;
  assign bus.out_to     = to_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: transaction-timing model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_div_arbiter;

  localparam int TO = 64;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  div_arbiter_if #(.TAG_W(4)) bus ();

  div_arbiter #(.TAG_W(4), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Divider FU stand-in: answers fu_lat cycles after fu_en (fu_lat < 0: never).
  int          fu_lat = -1;
  logic        auto_fin = 1'b0, man_fin = 1'b0;
  logic [31:0] auto_res = '0, man_res = '0;
  assign bus.fu_finish = auto_fin | man_fin;
  assign bus.fu_res    = man_fin ? man_res : auto_res;

  initial begin
    logic [31:0] q;
    forever begin
      @(negedge clk);
      if (bus.fu_en && fu_lat >= 0) begin
        q = (bus.fu_b != 0) ? bus.fu_a / bus.fu_b : 32'd0;
        repeat (fu_lat) @(posedge clk);
        #1 auto_fin = 1'b1; auto_res = q;
        @(posedge clk);
        #1 auto_fin = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  // Model: one operation in flight, tracked by cycle timestamps.
  bit          m_busy = 0, m_last = 1, m_done = 0, m_zero = 0, m_src = 0, m_dz = 0, m_to = 0;
  int          m_xc = 0, m_rc = 0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [3:0]  m_tag = '0;

  int          fu_en_count = 0, fu_en_cyc = -1, ov_count = 0;
  int          grant_q[$];
  int          osrc_q[$];
  logic [31:0] ores_q[$];

  initial begin
    logic exp_r0, exp_r1, exp_fu, exp_ov;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_last = 1; m_done = 0;
        chk("rst_ready0", 32'(bus.req0_ready), 0);
        chk("rst_ready1", 32'(bus.req1_ready), 0);
        chk("rst_fu_en", 32'(bus.fu_en), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_res", bus.out_res, 0);
        chk("rst_out_tag", 32'(bus.out_tag), 0);
        chk("rst_out_src", 32'(bus.out_src), 0);
        chk("rst_out_dz", 32'(bus.out_dz), 0);
        chk("rst_out_to", 32'(bus.out_to), 0);
      end else begin
        exp_r0 = 0;
        exp_r1 = 0;
        if (!m_busy) begin
          exp_r0 = bus.req0_valid && (!bus.req1_valid || m_last);
          exp_r1 = bus.req1_valid && (!bus.req0_valid || !m_last);
        end
        exp_fu = m_busy && !m_zero && (cyc == m_xc + 1);
        exp_ov = m_busy && m_done && (cyc >= m_rc);
        chk("m_ready0", 32'(bus.req0_ready), 32'(exp_r0));
        chk("m_ready1", 32'(bus.req1_ready), 32'(exp_r1));
        chk("m_fu_en", 32'(bus.fu_en), 32'(exp_fu));
        chk("m_out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (m_busy && !m_zero && !m_done && cyc >= m_xc + 1) begin
          chk("m_fu_a", bus.fu_a, m_a);
          chk("m_fu_b", bus.fu_b, m_b);
        end
        if (exp_ov) begin
          chk("m_out_res", bus.out_res, m_res);
          chk("m_out_tag", 32'(bus.out_tag), 32'(m_tag));
          chk("m_out_src", 32'(bus.out_src), 32'(m_src));
          chk("m_out_dz", 32'(bus.out_dz), 32'(m_dz));
          chk("m_out_to", 32'(bus.out_to), 32'(m_to));
        end
        if (exp_r0 || exp_r1) begin
          m_busy = 1; m_done = 0; m_src = exp_r1; m_last = exp_r1; m_xc = cyc;
          m_a    = exp_r1 ? bus.req1_a : bus.req0_a;
          m_b    = exp_r1 ? bus.req1_b : bus.req0_b;
          m_tag  = exp_r1 ? bus.req1_tag : bus.req0_tag;
          m_zero = (m_b == 0);
          if (m_zero) begin
            m_done = 1; m_rc = cyc + 1; m_res = 32'hFFFF_FFFF; m_dz = 1; m_to = 0;
          end
        end else if (m_busy && !m_done) begin
          if (cyc >= m_xc + 2 && bus.fu_finish) begin
            m_done = 1; m_rc = cyc + 1; m_res = bus.fu_res; m_dz = 0; m_to = 0;
          end else if (cyc == m_xc + 1 + TO) begin
            m_done = 1; m_rc = cyc + 1; m_res = 0; m_dz = 0; m_to = 1;
          end
        end else if (exp_ov && bus.out_ready) begin
          m_busy = 0;
        end
      end
      if (bus.fu_en) begin
        fu_en_count++;
        fu_en_cyc = cyc;
      end
      if (bus.req0_valid && bus.req0_ready) grant_q.push_back(0);
      if (bus.req1_valid && bus.req1_ready) grant_q.push_back(1);
      if (bus.out_valid) ov_count++;
      if (bus.out_valid && bus.out_ready) begin
        osrc_q.push_back(int'(bus.out_src));
        ores_q.push_back(bus.out_res);
      end
    end
  end

  task automatic wait_ready(input int n, output int xc);
    xc = -1;
    for (int i = 0; i < 200 && xc < 0; i++) begin
      @(negedge clk); #1;
      if ((n == 0 && bus.req0_ready) || (n == 1 && bus.req1_ready)) xc = cyc;
    end
    if (xc < 0) fail_now("wait_ready");
    @(posedge clk); #1;
    if (n == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic do_req(input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, output int xc);
    @(posedge clk); #1;
    if (n == 0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_tag = tag; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_tag = tag; bus.req1_valid = 1'b1;
    end
    wait_ready(n, xc);
  endtask

  task automatic wait_out(output int oc);
    oc = -1;
    for (int i = 0; i < 200 && oc < 0; i++) begin
      @(negedge clk); #1;
      if (bus.out_valid) oc = cyc;
    end
    if (oc < 0) fail_now("wait_out");
  endtask

  task automatic accept();
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    int xc, oc, ec, base, rdy_seen, drop_seen;
    bit got;
    rst_n = 1'b1;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_tag = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_tag = 0;
    bus.out_ready = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both requesters valid from reset: alternating grants starting at req0.
    fu_lat = 2;
    base = fu_en_count;
    grant_q.delete(); osrc_q.delete(); ores_q.delete();
    bus.req0_a = 40; bus.req0_b = 8; bus.req0_tag = 1; bus.req0_valid = 1;
    bus.req1_a = 21; bus.req1_b = 3; bus.req1_tag = 2; bus.req1_valid = 1;
    bus.out_ready = 1;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk); #1;
      if (grant_q.size() >= 4) got = 1;
    end
    if (!got) fail_now("rr_grants");
    @(posedge clk); #1 bus.req0_valid = 0; bus.req1_valid = 0;
    repeat (10) @(posedge clk);
    #1 bus.out_ready = 0;
    chk("rr_grant_count", grant_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), (i < grant_q.size()) ? grant_q[i] : 99, i % 2);
      chk($sformatf("rr_out_src%0d", i), (i < osrc_q.size()) ? osrc_q[i] : 99, i % 2);
      chk($sformatf("rr_out_res%0d", i), (i < ores_q.size()) ? ores_q[i] : 32'hDEAD,
          (i % 2 == 0) ? 32'd5 : 32'd7);
    end
    chk("rr_fu_en_pulses", fu_en_count - base, 4);

    // Basic divide, FU answers 10 cycles after issue.
    fu_lat = 10;
    base = fu_en_count;
    do_req(0, 100, 7, 3, xc);
    wait_out(oc);
    chk("div_issue_lat", fu_en_cyc, xc + 1);
    chk("div_result_lat", oc - fu_en_cyc, 11);
    chk("div_fu_en_pulses", fu_en_count - base, 1);
    chk("div_out_res", bus.out_res, 14);
    chk("div_out_tag", 32'(bus.out_tag), 3);
    chk("div_out_src", 32'(bus.out_src), 0);
    chk("div_out_dz", 32'(bus.out_dz), 0);
    accept();

    // Divide by zero bypasses the FU.
    base = fu_en_count;
    do_req(1, 5, 0, 4, xc);
    wait_out(oc);
    chk("dz_lat", oc - xc, 1);
    chk("dz_out_res", bus.out_res, 32'hFFFF_FFFF);
    chk("dz_out_dz", 32'(bus.out_dz), 1);
    chk("dz_out_src", 32'(bus.out_src), 1);
    chk("dz_fu_en_pulses", fu_en_count - base, 0);

    // Hold HOLD for 20 cycles with a pending request; accept only after exit.
    fu_lat = 1;
    @(posedge clk); #1;
    bus.req0_a = 9; bus.req0_b = 3; bus.req0_tag = 5; bus.req0_valid = 1;
    rdy_seen = 0;
    drop_seen = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (bus.req0_ready || bus.req1_ready) rdy_seen++;
      if (!bus.out_valid) drop_seen++;
    end
    chk("hold_ready_seen", rdy_seen, 0);
    chk("hold_valid_drops", drop_seen, 0);
    chk("hold_out_res", bus.out_res, 32'hFFFF_FFFF);
    @(posedge clk); #1 bus.out_ready = 1; ec = cyc;
    @(posedge clk); #1 bus.out_ready = 0;
    wait_ready(0, xc);
    chk("hold_next_xfer", xc, ec + 1);
    wait_out(oc);
    chk("hold_next_res", bus.out_res, 3);
    chk("hold_next_tag", 32'(bus.out_tag), 5);
    accept();

    // FU never answers: timeout result.
    fu_lat = -1;
    do_req(0, 50, 5, 7, xc);
    wait_out(oc);
    chk("to_issue_lat", fu_en_cyc, xc + 1);
    chk("to_result_lat", oc - fu_en_cyc, 65);
    chk("to_out_to", 32'(bus.out_to), 1);
    chk("to_out_res", bus.out_res, 0);
    chk("to_out_tag", 32'(bus.out_tag), 7);
    accept();

    // FU answers in the very cycle the timeout fires: the answer wins.
    fu_lat = 64;
    do_req(1, 1000, 10, 9, xc);
    wait_out(oc);
    chk("edge_result_lat", oc - fu_en_cyc, 65);
    chk("edge_out_to", 32'(bus.out_to), 0);
    chk("edge_out_res", bus.out_res, 100);
    chk("edge_out_src", 32'(bus.out_src), 1);
    accept();

    // Reset during WAIT, then a stray fu_finish must be ignored.
    fu_lat = -1;
    do_req(0, 20, 4, 2, xc);
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    base = ov_count;
    repeat (3) @(posedge clk);
    #1 man_fin = 1; man_res = 99;
    @(posedge clk); #1 man_fin = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_out_valid", ov_count - base, 0);

    // After reset req0 wins contention again even though req0 was granted last.
    fu_lat = 1;
    grant_q.delete();
    bus.req0_a = 6; bus.req0_b = 2; bus.req0_tag = 1; bus.req0_valid = 1;
    bus.req1_a = 8; bus.req1_b = 2; bus.req1_tag = 1; bus.req1_valid = 1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      if (grant_q.size() >= 1) got = 1;
    end
    if (!got) fail_now("post_rst_grant");
    @(posedge clk); #1 bus.req0_valid = 0; bus.req1_valid = 0;
    chk("post_rst_grant", (grant_q.size() > 0) ? grant_q[0] : 99, 0);
    wait_out(oc);
    chk("post_rst_res", bus.out_res, 3);
    accept();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
